// File: rtl/core_pkg.sv
// Shared pipeline-control types: per-stage metadata, halt FSM states and the
// bubble encoding that the hazard controller drops into stage 0.
package core_pkg;

   localparam int unsigned CORE_AW = 5;

   typedef struct packed {
      logic               valid;
      logic [CORE_AW-1:0] rd;
      logic               wen;
      logic               is_load;
      logic               is_halt;
   } stage_meta_t;

   typedef enum logic [1:0] {
      HS_RUN    = 2'd0,
      HS_DRAIN  = 2'd1,
      HS_HALTED = 2'd2
   } halt_state_e;

   localparam logic [CORE_AW-1:0] NOP_RD   = {CORE_AW{1'b0}};
   localparam stage_meta_t        NOP_META = '{valid: 1'b0, rd: NOP_RD, wen: 1'b0,
                                               is_load: 1'b0, is_halt: 1'b0};

   // A stage really writes the register file only if valid, enabled and not x0.
   function automatic logic eff_wen(input stage_meta_t m);
      return m.valid && m.wen && (m.rd != NOP_RD);
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding selector: youngest producing stage among 1..NS-1
// wins; loads only forward once their data has reached LOAD_STAGE.
module fwd_mux
   import core_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int AW         = 5,
   parameter int NS         = 3,
   parameter int LOAD_STAGE = 2
) (
   input  logic [AW-1:0]          r,
   input  logic [XLEN-1:0]        rf,
   input  stage_meta_t [NS-1:1]   meta,
   input  logic [NS*XLEN-1:XLEN]  st_hi,
   output logic [XLEN-1:0]        op,
   output logic [2:0]             sel
);

   logic match_s;

   // Walk oldest to youngest so the youngest match overwrites earlier ones.
   always_comb begin
      op      = rf;
      sel     = 3'd0;
      match_s = 1'b0;
      for (int k = NS - 1; k >= 1; k--) begin
         match_s = (r != {AW{1'b0}}) && eff_wen(meta[k]) && (meta[k].rd == r) &&
                   (!meta[k].is_load || (k >= LOAD_STAGE));
         op  = match_s ? st_hi[k*XLEN +: XLEN] : op;
         sel = match_s ? 3'(k) : sel;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Post-decode pipeline control: metadata chain, operand forwarding,
// load-use stall, flush bubbles and sticky halt drain.
module pipe_hazard_ctrl
   import core_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int AW         = 5,
   parameter int NS         = 3,
   parameter int LOAD_STAGE = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [AW-1:0]      id_rs1,
   input  logic [AW-1:0]      id_rs2,
   input  logic [AW-1:0]      id_rd,
   input  logic               id_wen,
   input  logic               id_is_load,
   input  logic               id_is_halt,
   output logic               id_ready,
   input  logic               flush,
   input  logic [XLEN-1:0]    ex_rf1,
   input  logic [XLEN-1:0]    ex_rf2,
   input  logic [NS*XLEN-1:0] st_result,
   output logic [XLEN-1:0]    ex_op1,
   output logic [XLEN-1:0]    ex_op2,
   output logic [2:0]         fwd_sel1,
   output logic [2:0]         fwd_sel2,
   output logic [NS-1:0]      stage_valid,
   output logic               wb_valid,
   output logic               wb_wen,
   output logic [AW-1:0]      wb_rd,
   output logic               halted
);

   stage_meta_t [NS-1:0] stage_q, stage_d;
   logic [AW-1:0]        ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   halt_state_e          halt_state_q, halt_state_d;
   logic                 stall_s, halt_pend_s, accept_s;
   logic                 unused_s;

   // Load-use hazard against loads whose data is not yet forwardable.
   always_comb begin
      stall_s = 1'b0;
      for (int k = 0; k < NS; k++) begin
         stall_s = stall_s | ((k + 1 < LOAD_STAGE) && id_valid &&
                   stage_q[k].valid && stage_q[k].is_load &&
                   (((id_rs1 != {AW{1'b0}}) && (stage_q[k].rd == id_rs1)) ||
                    ((id_rs2 != {AW{1'b0}}) && (stage_q[k].rd == id_rs2))));
      end
   end

   // Issue decision, metadata shift and halt FSM next state.
   always_comb begin
      halt_pend_s = (halt_state_q != HS_RUN);
      id_ready    = !flush && !halt_pend_s && !stall_s;
      accept_s    = id_valid && id_ready;
      if (accept_s) begin
         stage_d[0].valid   = 1'b1;
         stage_d[0].rd      = id_rd;
         stage_d[0].wen     = id_wen;
         stage_d[0].is_load = id_is_load;
         stage_d[0].is_halt = id_is_halt;
         ex_rs1_d           = id_rs1;
         ex_rs2_d           = id_rs2;
      end else begin
         stage_d[0] = NOP_META;
         ex_rs1_d   = {AW{1'b0}};
         ex_rs2_d   = {AW{1'b0}};
      end
      for (int k = 1; k < NS; k++) begin
         stage_d[k] = stage_q[k-1];
      end
      case (halt_state_q)
         HS_RUN:    halt_state_d = (accept_s && id_is_halt) ? HS_DRAIN : HS_RUN;
         HS_DRAIN:  halt_state_d = (stage_q[NS-2].valid && stage_q[NS-2].is_halt) ?
                                   HS_HALTED : HS_DRAIN;
         HS_HALTED: halt_state_d = HS_HALTED;
         default:   halt_state_d = HS_RUN;
      endcase
   end

   // Pipeline metadata, stage-0 source registers and halt FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q      <= {NS{NOP_META}};
         ex_rs1_q     <= {AW{1'b0}};
         ex_rs2_q     <= {AW{1'b0}};
         halt_state_q <= HS_RUN;
      end else begin
         stage_q      <= stage_d;
         ex_rs1_q     <= ex_rs1_d;
         ex_rs2_q     <= ex_rs2_d;
         halt_state_q <= halt_state_d;
      end
   end

   // Status outputs decoded straight from flops.
   always_comb begin
      for (int k = 0; k < NS; k++) begin
         stage_valid[k] = stage_q[k].valid;
      end
      wb_valid = stage_q[NS-1].valid;
      wb_wen   = eff_wen(stage_q[NS-1]);
      wb_rd    = stage_q[NS-1].rd;
      halted   = (halt_state_q == HS_HALTED);
   end

   assign unused_s = ^{st_result[XLEN-1:0], stage_q[NS-1].is_halt};

   fwd_mux #(.XLEN(XLEN), .AW(AW), .NS(NS), .LOAD_STAGE(LOAD_STAGE)) u_fwd1 (
      .r     (ex_rs1_q),
      .rf    (ex_rf1),
      .meta  (stage_q[NS-1:1]),
      .st_hi (st_result[NS*XLEN-1:XLEN]),
      .op    (ex_op1),
      .sel   (fwd_sel1)
   );

   fwd_mux #(.XLEN(XLEN), .AW(AW), .NS(NS), .LOAD_STAGE(LOAD_STAGE)) u_fwd2 (
      .r     (ex_rs2_q),
      .rf    (ex_rf2),
      .meta  (stage_q[NS-1:1]),
      .st_hi (st_result[NS*XLEN-1:XLEN]),
      .op    (ex_op2),
      .sel   (fwd_sel2)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl with NS = 3, LOAD_STAGE = 2.
module tb_pipe_hazard_ctrl;

   localparam int XLEN = 64;
   localparam int AW   = 5;
   localparam int NS   = 3;
   localparam int LS   = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               id_valid = 1'b0;
   logic [AW-1:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic               id_wen = 1'b0, id_is_load = 1'b0, id_is_halt = 1'b0;
   logic               id_ready;
   logic               flush = 1'b0;
   logic [XLEN-1:0]    ex_rf1 = '0, ex_rf2 = '0;
   logic [NS*XLEN-1:0] st_result = '0;
   logic [XLEN-1:0]    ex_op1, ex_op2;
   logic [2:0]         fwd_sel1, fwd_sel2;
   logic [NS-1:0]      stage_valid;
   logic               wb_valid, wb_wen;
   logic [AW-1:0]      wb_rd;
   logic               halted;

   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_fails  = 0;

   pipe_hazard_ctrl #(.XLEN(XLEN), .AW(AW), .NS(NS), .LOAD_STAGE(LS)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .id_is_halt(id_is_halt),
      .id_ready(id_ready), .flush(flush), .ex_rf1(ex_rf1), .ex_rf2(ex_rf2),
      .st_result(st_result), .ex_op1(ex_op1), .ex_op2(ex_op2), .fwd_sel1(fwd_sel1),
      .fwd_sel2(fwd_sel2), .stage_valid(stage_valid), .wb_valid(wb_valid),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input logic [63:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
         end
      end
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic wen, input logic ld,
                        input logic hlt);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_wen = wen; id_is_load = ld; id_is_halt = hlt;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_st(input int k, input logic [XLEN-1:0] v);
      st_result[k*XLEN +: XLEN] = v;
   endtask

   initial begin
      ex_rf1 = 64'h111;
      ex_rf2 = 64'h222;
      // reset state
      #1 rst_n = 1'b0;
      push(64'd0); push(64'd0); push(64'd0); push(64'd0); push(64'd0); push(64'd1);
      #1;
      chk("rst_stage_valid", 64'(stage_valid));
      chk("rst_wb_valid", 64'(wb_valid));
      chk("rst_wb_wen", 64'(wb_wen));
      chk("rst_wb_rd", 64'(wb_rd));
      chk("rst_halted", 64'(halted));
      chk("rst_id_ready", 64'(id_ready));
      #8 rst_n = 1'b1;
      tick;

      // back-to-back ALU dependency
      drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
      push(64'd1); #1 chk("alu_ready_addi", 64'(id_ready));
      tick;
      drive(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
      push(64'd1); #1 chk("alu_ready_add", 64'(id_ready));
      tick;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      set_st(1, 64'd5);
      push(64'd5); push(64'd5); push(64'd1); push(64'd1); push(64'b011);
      #1;
      chk("alu_ex_op1", ex_op1);
      chk("alu_ex_op2", ex_op2);
      chk("alu_fwd_sel1", 64'(fwd_sel1));
      chk("alu_fwd_sel2", 64'(fwd_sel2));
      chk("alu_stage_valid", 64'(stage_valid));

      // load-use: exactly one bubble, then forward from stage 2
      drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
      push(64'd1); #1 chk("lu_ready_ld", 64'(id_ready));
      tick;
      drive(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
      push(64'd0); #1 chk("lu_stall", 64'(id_ready));
      tick;
      push(64'd1); #1 chk("lu_release", 64'(id_ready));
      tick;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      set_st(1, 64'h5555);
      set_st(2, 64'hDEAD);
      push(64'd2); push(64'hDEAD); push(64'd0); push(64'h222);
      push(64'b101); push(64'd1); push(64'd3); push(64'd1);
      #1;
      chk("lu_fwd_sel1", 64'(fwd_sel1));
      chk("lu_ex_op1", ex_op1);
      chk("lu_fwd_sel2", 64'(fwd_sel2));
      chk("lu_ex_op2", ex_op2);
      chk("lu_stage_valid", 64'(stage_valid));
      chk("lu_wb_valid", 64'(wb_valid));
      chk("lu_wb_rd", 64'(wb_rd));
      chk("lu_wb_wen", 64'(wb_wen));

      // writes to x0 never forward and never count as a register write
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      set_st(1, 64'hBB);
      set_st(2, 64'hAA);
      push(64'd0); push(64'd0); push(64'h111); push(64'd1); push(64'd0);
      #1;
      chk("x0_fwd_sel1", 64'(fwd_sel1));
      chk("x0_fwd_sel2", 64'(fwd_sel2));
      chk("x0_ex_op1", ex_op1);
      chk("x0_wb_valid", 64'(wb_valid));
      chk("x0_wb_wen", 64'(wb_wen));

      // youngest producer wins
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b1, 5'd5, 5'd5, 5'd11, 1'b1, 1'b0, 1'b0);
      push(64'd1); #1 chk("pri_ready", 64'(id_ready));
      tick;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      set_st(1, 64'd7);
      set_st(2, 64'd9);
      push(64'd7); push(64'd1); push(64'd7); push(64'd1);
      #1;
      chk("pri_ex_op1", ex_op1);
      chk("pri_fwd_sel1", 64'(fwd_sel1));
      chk("pri_ex_op2", ex_op2);
      chk("pri_fwd_sel2", 64'(fwd_sel2));

      // flush during a load-use stall
      drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
      tick;
      drive(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      push(64'd0); #1 chk("fl_ready", 64'(id_ready));
      tick;
      flush = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      push(64'b110); push(64'd11); #1;
      chk("fl_stage_valid_a", 64'(stage_valid));
      chk("fl_wb_rd_a", 64'(wb_rd));
      tick;
      push(64'd1); push(64'd8); push(64'b100);
      chk("fl_wb_valid_b", 64'(wb_valid));
      chk("fl_wb_rd_b", 64'(wb_rd));
      chk("fl_stage_valid_b", 64'(stage_valid));

      // halt drain
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      push(64'd1); #1 chk("h_ready_halt", 64'(id_ready));
      tick;
      drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
      push(64'd0); push(64'd0); push(64'b001); #1;
      chk("h_ready_n0", 64'(id_ready));
      chk("h_halted_n0", 64'(halted));
      chk("h_stage_valid_n0", 64'(stage_valid));
      tick;
      push(64'd0); push(64'b010);
      chk("h_halted_n1", 64'(halted));
      chk("h_stage_valid_n1", 64'(stage_valid));
      tick;
      push(64'd1); push(64'd1); push(64'd0);
      chk("h_halted_n2", 64'(halted));
      chk("h_wb_valid_n2", 64'(wb_valid));
      chk("h_ready_n2", 64'(id_ready));
      for (int i = 0; i < 20; i++) begin
         tick;
         push(64'd1);
         chk("h_halted_hold", 64'(halted));
      end
      push(64'd0); push(64'd0);
      chk("h_stage_valid_end", 64'(stage_valid));
      chk("h_ready_end", 64'(id_ready));

      // reset while halted, then reset mid-drain
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      push(64'd0); #1 chk("r_halted_a", 64'(halted));
      tick;
      #2 rst_n = 1'b1;
      tick;
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick;
      push(64'b010); push(64'd0);
      chk("r_drain_stage_valid", 64'(stage_valid));
      chk("r_drain_ready", 64'(id_ready));
      #2 rst_n = 1'b0;
      push(64'd0); push(64'd0); push(64'd1); #1;
      chk("r_mid_halted", 64'(halted));
      chk("r_mid_stage_valid", 64'(stage_valid));
      chk("r_mid_ready", 64'(id_ready));
      tick;
      #2 rst_n = 1'b1;
      tick;
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
      push(64'd1); #1 chk("r_resume_ready", 64'(id_ready));
      tick;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      push(64'b001); chk("r_resume_stage0", 64'(stage_valid));
      tick;
      tick;
      push(64'd1); push(64'd10); push(64'd1); push(64'd0);
      chk("r_resume_wb_valid", 64'(wb_valid));
      chk("r_resume_wb_rd", 64'(wb_rd));
      chk("r_resume_wb_wen", 64'(wb_wen));
      chk("r_resume_halted", 64'(halted));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
